// File: rtl/rf_bridge_defs.sv
// Shared definitions for the RF GPIO register bridge: FSM encoding and
// GPIO field positions, given as bit offsets counted down from the word MSB.
package rf_bridge_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Request word: [MSB] request, [MSB-1] address MSB (1 = read).
    // Response word: [MSB] ack, [MSB-1] address error.
    localparam int REQ_BIT  = 0;
    localparam int ADDR_MSB = 1;
    localparam int RW_BIT   = 1;
    localparam int ERR_BIT  = 1;

endpackage

// File: rtl/rf_gpio_bridge_wr_bank.sv
// Write register bank: one register and one strobe per index, with optional
// self-clearing registers that hold written data for the strobe cycle only.
module rf_wr_bank #(
    parameter int                   N_WR_REGS       = 64,
    parameter int                   NB_DATA         = 22,
    parameter int                   NB_IDX          = 8,
    parameter logic [N_WR_REGS-1:0] SELF_CLEAR_MASK = '0
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_wr_en,
    input  logic [NB_IDX-1:0]              i_wr_idx,
    input  logic [NB_DATA-1:0]             i_wr_data,
    output logic [N_WR_REGS*NB_DATA-1:0]   o_wr_regs,
    output logic [N_WR_REGS-1:0]           o_wr_strobe
);

    for (genvar k = 0; k < N_WR_REGS; k++) begin : g_reg
        logic               hit;
        logic [NB_DATA-1:0] reg_q;
        logic               stb_q;

        assign hit = i_wr_en && (i_wr_idx == NB_IDX'(k));

        always_ff @(posedge i_clock) begin
            if (!i_reset) begin
                reg_q <= '0;
                stb_q <= 1'b0;
            end else begin
                stb_q <= hit;
                if (hit)
                    reg_q <= i_wr_data;
                else if (SELF_CLEAR_MASK[k])
                    reg_q <= '0;
            end
        end

        assign o_wr_regs[k*NB_DATA +: NB_DATA] = reg_q;
        assign o_wr_strobe[k]                  = stb_q;
    end

endmodule

// File: rtl/rf_gpio_bridge.sv
// Level-handshake bridge from the processor GPIO pair to the PCS register
// space: latched request, one EXEC cycle, then ack held until request drops.
module rf_gpio_bridge
    import rf_bridge_defs::*;
#(
    parameter int                   NB_GPIO         = 32,
    parameter int                   NB_ADDR         = 9,
    parameter int                   NB_DATA         = 22,
    parameter int                   N_WR_REGS       = 64,
    parameter int                   N_RD_REGS       = 64,
    parameter int                   NB_RD_WORD      = 30,
    parameter logic [N_WR_REGS-1:0] SELF_CLEAR_MASK = {N_WR_REGS{1'b0}}
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic [NB_GPIO-1:0]              i_gpio_data,
    output logic [NB_GPIO-1:0]              o_gpio_data,
    output logic [N_WR_REGS*NB_DATA-1:0]    o_wr_regs,
    output logic [N_WR_REGS-1:0]            o_wr_strobe,
    input  logic [N_RD_REGS*NB_RD_WORD-1:0] i_rd_regs,
    output logic [N_RD_REGS-1:0]            o_cor_pulse
);

    localparam int NB_IDX   = NB_ADDR - 1;
    localparam int REQ_POS  = NB_GPIO - 1 - REQ_BIT;
    localparam int ADDR_POS = NB_GPIO - 1 - ADDR_MSB;
    localparam int RW_POS   = NB_GPIO - 1 - RW_BIT;
    localparam int ERR_POS  = NB_GPIO - 1 - ERR_BIT;
    localparam int RD_IW    = (N_RD_REGS > 1) ? $clog2(N_RD_REGS) : 1;

    state_e                 state_q, state_d;
    logic                   req;
    logic                   req_q;
    logic                   arm_q;
    logic                   start;
    logic                   exec;
    logic                   rw_q;
    logic [NB_IDX-1:0]      idx_q;
    logic [NB_DATA-1:0]     data_q;
    logic [NB_RD_WORD-1:0]  rd_q;
    logic                   err_q;
    logic [N_RD_REGS-1:0]   cor_q, cor_d;
    logic                   wr_ok, rd_ok;
    logic [NB_RD_WORD-1:0]  rd_arr [N_RD_REGS];

    assign req = i_gpio_data[REQ_POS];
    // arm_q blocks a request that was already high when reset released.
    assign start = (state_q == ST_IDLE) && req && !req_q && arm_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        exec    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_EXEC;
            ST_EXEC: begin
                exec    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: if (!req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar k = 0; k < N_RD_REGS; k++) begin : g_rd
        assign rd_arr[k] = i_rd_regs[k*NB_RD_WORD +: NB_RD_WORD];
    end

    assign wr_ok = !rw_q && ({1'b0, idx_q} < (NB_IDX+1)'(N_WR_REGS));
    assign rd_ok =  rw_q && ({1'b0, idx_q} < (NB_IDX+1)'(N_RD_REGS));

    always_comb begin
        cor_d = '0;
        if (exec && rd_ok) cor_d[idx_q[RD_IW-1:0]] = 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            req_q  <= 1'b0;
            arm_q  <= 1'b0;
            rw_q   <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
            cor_q  <= '0;
        end else begin
            req_q <= req;
            if (!req) arm_q <= 1'b1;
            if (start) begin
                rw_q   <= i_gpio_data[RW_POS];
                idx_q  <= i_gpio_data[ADDR_POS-1 -: NB_IDX];
                data_q <= i_gpio_data[NB_DATA-1:0];
            end
            cor_q <= cor_d;
            if (exec) begin
                err_q <= !(wr_ok || rd_ok);
                rd_q  <= rd_ok ? rd_arr[idx_q[RD_IW-1:0]] : '0;
            end
        end
    end

    rf_wr_bank #(
        .N_WR_REGS       (N_WR_REGS),
        .NB_DATA         (NB_DATA),
        .NB_IDX          (NB_IDX),
        .SELF_CLEAR_MASK (SELF_CLEAR_MASK)
    ) u_wr_bank (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_wr_en     (exec && wr_ok),
        .i_wr_idx    (idx_q),
        .i_wr_data   (data_q),
        .o_wr_regs   (o_wr_regs),
        .o_wr_strobe (o_wr_strobe)
    );

    always_comb begin
        o_gpio_data                   = '0;
        o_gpio_data[REQ_POS]          = (state_q == ST_DONE);
        o_gpio_data[ERR_POS]          = err_q;
        o_gpio_data[NB_RD_WORD-1:0]   = rd_q;
    end

    assign o_cor_pulse = cor_q;

endmodule

// File: tb/tb_rf_gpio_bridge.sv
// Randomized self-checking bench for rf_gpio_bridge against a transaction-level model.
module tb_rf_gpio_bridge;

    localparam int          NW   = 64;
    localparam int          NR   = 64;
    localparam int          ND   = 22;
    localparam int          NRW  = 30;
    localparam logic [63:0] MASK = 64'h0000_0100_0000_0080;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [31:0]        gpio_in;
    logic [31:0]        gpio_out;
    logic [NW*ND-1:0]   wr_regs;
    logic [NW-1:0]      wr_stb;
    logic [NR*NRW-1:0]  rd_regs;
    logic [NR-1:0]      cor;

    int n_chk  = 0;
    int n_fail = 0;

    logic [ND-1:0]  bank_m [NW];
    logic [NRW-1:0] rdbus  [NR];
    logic [NRW-1:0] rd_m;
    logic           err_m;

    always #5 clk = ~clk;

    rf_gpio_bridge #(
        .NB_GPIO(32), .NB_ADDR(9), .NB_DATA(ND), .N_WR_REGS(NW),
        .N_RD_REGS(NR), .NB_RD_WORD(NRW), .SELF_CLEAR_MASK(MASK)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_gpio_data (gpio_in),
        .o_gpio_data (gpio_out),
        .o_wr_regs   (wr_regs),
        .o_wr_strobe (wr_stb),
        .i_rd_regs   (rd_regs),
        .o_cor_pulse (cor)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_rdbus(input bit rerand);
        for (int k = 0; k < NR; k++) begin
            if (rerand) rdbus[k] = NRW'($urandom);
            rd_regs[k*NRW +: NRW] = rdbus[k];
        end
    endtask

    task automatic check_bank(input string tag);
        for (int k = 0; k < NW; k++)
            chk(tag, 64'(wr_regs[k*ND +: ND]), 64'(bank_m[k]));
    endtask

    task automatic check_idle_outs(input string tag, input logic ack);
        chk({tag, "_resp"}, 64'(gpio_out), 64'({ack, err_m, rd_m}));
        chk({tag, "_stb"},  64'(wr_stb),   64'd0);
        chk({tag, "_cor"},  64'(cor),      64'd0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NW; k++) bank_m[k] = '0;
        rd_m  = '0;
        err_m = 1'b0;
    endtask

    // One full handshake: raise request, check EXEC, DONE/strobe, hold, drop.
    task automatic txn(input logic rw, input logic [7:0] idx, input logic [ND-1:0] data,
                       input int hold);
        logic        in_wr, in_rd;
        logic [63:0] exp_stb, exp_cor;
        in_wr   = !rw && (idx < NW);
        in_rd   =  rw && (idx < NR);
        exp_stb = in_wr ? (64'd1 << idx) : 64'd0;
        exp_cor = in_rd ? (64'd1 << idx) : 64'd0;

        @(negedge clk);
        gpio_in = {1'b1, rw, idx, data};
        @(negedge clk);
        check_idle_outs("exec", 1'b0);

        err_m = !(in_wr || in_rd);
        rd_m  = in_rd ? rdbus[idx] : '0;
        if (in_wr) bank_m[idx] = data;
        @(negedge clk);
        chk("done_resp", 64'(gpio_out), 64'({1'b1, err_m, rd_m}));
        chk("done_stb",  64'(wr_stb),   exp_stb);
        chk("done_cor",  64'(cor),      exp_cor);
        check_bank("done_bank");

        drive_rdbus(1'b1);
        if (in_wr && MASK[idx]) bank_m[idx] = '0;
        repeat (hold) begin
            @(negedge clk);
            check_idle_outs("hold", 1'b1);
        end
        @(negedge clk);
        check_idle_outs("post", 1'b1);
        check_bank("post_bank");
        gpio_in[31] = 1'b0;
        @(negedge clk);
        check_idle_outs("drop", 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        gpio_in = {1'b1, 1'b0, 8'd5, 22'h3FFFFF};
        model_reset();
        drive_rdbus(1'b1);

        repeat (3) @(negedge clk);
        check_idle_outs("rst", 1'b0);
        check_bank("rst_bank");

        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_idle_outs("rel_hi", 1'b0);
        end
        gpio_in[31] = 1'b0;
        @(negedge clk);

        txn(1'b0, 8'd5, 22'h2A5A5A, 0);
        rdbus[3] = 30'h1234567;
        drive_rdbus(1'b0);
        txn(1'b1, 8'd3, 22'd0, 1);
        txn(1'b0, 8'd70, 22'h155555, 0);
        txn(1'b1, 8'd10, 22'd0, 0);
        txn(1'b0, 8'd7, 22'h1, 0);
        txn(1'b0, 8'd40, 22'h3ABCDE, 2);

        // Reset while a read of index 2 is in EXEC.
        @(negedge clk);
        gpio_in = {1'b1, 1'b1, 8'd2, 22'd0};
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_idle_outs("rst_exec", 1'b0);
        end
        check_bank("rst_exec_bank");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle_outs("rst_rel", 1'b0);
        end
        gpio_in[31] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] idx;
            idx = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(64, 255))
                                              : 8'($urandom_range(0, 63));
            if (i % 8 == 0) idx = 8'd7;
            txn(1'($urandom_range(0, 1)), idx, ND'($urandom), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_gpio_bridge.md
# rf_gpio_bridge

Parametrised register-file bridge between the soft processor's 32-bit GPIO pair and the PCS register space. It is the successor to the fixed-width write/read-mux split. Each request is a level-handshake: the processor raises a request bit, and the bridge answers with a matching ack bit. Write registers come with one-cycle strobes and optional self-clearing bits. Read registers come with a clear-on-read (COR) pulse issued after capture, and out-of-range addresses are flagged. The bridge sits on the RF clock between the processor GPIO and the PCS loopback top.

## Interface
- NB_GPIO, 32: GPIO word width.
- NB_ADDR, 9: address field width; MSB selects read (1) or write (0), the remaining bits are the register index.
- NB_DATA, 22: write data field width; NB_GPIO must be ≥ NB_ADDR+NB_DATA+1.
- N_WR_REGS, 64: number of write registers; must be ≤ 2^(NB_ADDR-1).
- N_RD_REGS, 64: number of read registers; must be ≤ 2^(NB_ADDR-1).
- NB_RD_WORD, 30: read word width; must be ≤ NB_GPIO-2.
- SELF_CLEAR_MASK, {N_WR_REGS{1'b0}}: bit k=1 makes write register k self-clearing.
- i_clock  in  1  RF clock.
- i_reset  in  1  synchronous, active-low reset.
- i_gpio_data  in  NB_GPIO  processor request word:
  - [NB_GPIO-1] request;
  - [NB_GPIO-2 -: NB_ADDR] address;
  - [NB_DATA-1:0] write data.
- o_gpio_data  out  NB_GPIO  response word:
  - [NB_GPIO-1] ack;
  - [NB_GPIO-2] addr_err;
  - [NB_RD_WORD-1:0] read data;
  - all other bits 0.
- o_wr_regs  out  N_WR_REGS*NB_DATA  flattened write register bank; register k occupies [k*NB_DATA +: NB_DATA].
- o_wr_strobe  out  N_WR_REGS  one-cycle pulse marking that register k was written.
- i_rd_regs  in  N_RD_REGS*NB_RD_WORD  flattened status bus.
- o_cor_pulse  out  N_RD_REGS  one-cycle clear-on-read pulse for read register k.

## Operation
- Request detection: a rising edge of the request bit (registered previous value 0, current value 1) is detected only in state IDLE. The address and data fields are latched on that same cycle.
- FSM states: IDLE, EXEC, DONE.
  - IDLE→EXEC on a detected rising edge.
  - EXEC→DONE unconditionally.
  - DONE→IDLE when the request bit is sampled at 0.
- EXEC, write with index < N_WR_REGS: the register is loaded with the latched data.
- EXEC, read with index < N_RD_REGS: i_rd_regs[index] is captured into the read-data field.
- EXEC, index out of range: no register changes, no strobe and no COR pulse are issued, read data is 0 and addr_err is set to 1.
- Ack is 1 exactly while the FSM is in DONE.
- addr_err and read data hold their values until the next request reaches EXEC. A write clears read data to 0.
- Self-clearing register k: its value is visible for exactly one cycle (the strobe cycle), then returns to 0.
- Reset clears all of the following to 0: every output, every write register, the FSM (to IDLE) and the edge register. Reset asserted mid-request aborts the request with no strobe or COR pulse. After reset is released, a request bit that is already high does not start a request until it has gone low and high again.
- Request bit toggling during EXEC or DONE: no new request is started. A stable high request is held in DONE.

## Timing
- Cycle 0: rising edge detected and fields latched.
- Cycle 1: EXEC.
- Cycle 2 onward (write): register value visible, o_wr_strobe[k] high for cycle 2 only.
- Cycle 2 onward (read): read data and addr_err visible, o_cor_pulse[k] high for cycle 2 only. The pulse therefore follows capture, so no count is lost.
- Ack goes to 1 in cycle 2.
- Ack-drop latency: request sampled 0 in cycle n gives ack = 0 in cycle n+1.
- Fastest request rate: one request per 4 cycles.
- At most one bit of o_wr_strobe or o_cor_pulse is high in any cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared header rf_bridge_defs holds:
  - FSM state encodings (2 bits);
  - GPIO field offset localparams: REQ_BIT, ADDR_MSB, RW_BIT, ERR_BIT.
- One sub-module, rf_wr_bank, holds the N_WR_REGS×NB_DATA storage. Its inputs are the write index, data and enable, plus SELF_CLEAR_MASK. Its outputs are the flattened bank and the strobes.
- Index decode, read capture, the COR one-hot, the FSM and the response word stay in the top module.

## Test plan
- Reset with request held high → all outputs 0. Releasing reset with request still high → no ack. Dropping request then raising it → ack in cycle 2.
- Write index 5 with data 0x2A5A5A → o_wr_regs[5] = 0x2A5A5A and o_wr_strobe = 1<<5 from cycle 2. Drop request → ack low one cycle later, register still holds 0x2A5A5A.
- Read index 3 with i_rd_regs[3] = 0x1234567 → read field = 0x1234567 and o_cor_pulse[3] high for exactly cycle 2. Changing i_rd_regs[3] afterwards does not alter the read field.
- Write index 70 (N_WR_REGS = 64) → addr_err = 1, ack = 1, no strobe, bank unchanged. The next valid read clears addr_err.
- SELF_CLEAR_MASK bit 7 set, write 0x1 to index 7 → value 0x1 in cycle 2 only, 0 from cycle 3.
- Reset (i_reset = 0) during EXEC of a read of index 2 → no o_cor_pulse, ack stays 0, FSM in IDLE.
